xgmii_deinterleave_pipe: RTL and testbench



---
 rtl/xgmii_deinterleave_pipe.sv | 196 +++++++++++++++++++
 tb/tb_xgmii_deinterleave_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_deinterleave_pipe.sv
// XGMII packed {ctrl,data} deinterleaver with control-code checking, optional
// 2:1 gearbox and a ready/valid output stage backed by a one-entry skid buffer.
module xgmii_deinterleave_pipe #(
  parameter int DATA_WIDTH  = 64,
  parameter int RATIO       = 1,
  parameter int ERR_REPLACE = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH/8*9-1:0]     in_xgmii_dc,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_align,
  output logic [DATA_WIDTH*RATIO-1:0]   out_xgmii_d,
  output logic [DATA_WIDTH/8*RATIO-1:0] out_xgmii_c,
  output logic [DATA_WIDTH/8*RATIO-1:0] out_cerr,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int L  = DATA_WIDTH / 8;
  localparam int OW = DATA_WIDTH * RATIO;
  localparam int OL = L * RATIO;

  function automatic logic code_legal(input logic [7:0] b);
    case (b)
      8'h07, 8'hFB, 8'hFD, 8'h9C, 8'hFE, 8'h5C: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] dec_d;
  logic [L-1:0]          dec_c;
  logic [L-1:0]          dec_e;
  logic                  in_ready_q, in_ready_d;
  logic                  accept;

  logic                  commit;
  logic [OW-1:0]         commit_d;
  logic [OL-1:0]         commit_c;
  logic [OL-1:0]         commit_e;

  assign accept   = in_valid & in_ready_q;
  assign in_ready = in_ready_q;

  // Split each packed lane and flag/replace illegal control codes.
  always_comb begin
    dec_d = '0;
    dec_c = '0;
    dec_e = '0;
    for (int k = 0; k < L; k++) begin
      dec_d[8*k +: 8] = in_xgmii_dc[9*k +: 8];
      dec_c[k]        = in_xgmii_dc[9*k + 8];
      dec_e[k]        = in_xgmii_dc[9*k + 8] & ~code_legal(in_xgmii_dc[9*k +: 8]);
      if (dec_e[k] && (ERR_REPLACE != 0)) begin
        dec_d[8*k +: 8] = 8'hFE;
        dec_c[k]        = 1'b1;
      end
    end
  end

  if (RATIO == 2) begin : g_gearbox
    logic                  phase_q, phase_d;
    logic                  eff_phase;
    logic [DATA_WIDTH-1:0] asm_d_q, asm_d_d;
    logic [L-1:0]          asm_c_q, asm_c_d;
    logic [L-1:0]          asm_e_q, asm_e_d;

    // An aligned word always restarts assembly, abandoning any pending low half.
    assign eff_phase = in_align ? 1'b0 : phase_q;

    // Phase 0 words park in the low half; phase 1 words complete and commit.
    always_comb begin
      phase_d = phase_q;
      asm_d_d = asm_d_q;
      asm_c_d = asm_c_q;
      asm_e_d = asm_e_q;
      commit  = 1'b0;
      if (accept) begin
        if (!eff_phase) begin
          asm_d_d = dec_d;
          asm_c_d = dec_c;
          asm_e_d = dec_e;
          phase_d = 1'b1;
        end else begin
          commit  = 1'b1;
          phase_d = 1'b0;
        end
      end
    end

    assign commit_d = {dec_d, asm_d_q};
    assign commit_c = {dec_c, asm_c_q};
    assign commit_e = {dec_e, asm_e_q};

    // Gearbox phase register; reset drops any half-assembled word.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) phase_q <= 1'b0;
      else        phase_q <= phase_d;
    end

    // Low-half assembly data, qualified by phase so no reset needed.
    always_ff @(posedge clk) begin
      asm_d_q <= asm_d_d;
      asm_c_q <= asm_c_d;
      asm_e_q <= asm_e_d;
    end
  end else begin : g_direct
    logic unused_align;
    assign unused_align = in_align;
    assign commit   = accept;
    assign commit_d = dec_d;
    assign commit_c = dec_c;
    assign commit_e = dec_e;
  end

  logic          out_valid_q, out_valid_d;
  logic [OW-1:0] out_d_q, out_d_d;
  logic [OL-1:0] out_c_q, out_c_d;
  logic [OL-1:0] out_e_q, out_e_d;
  logic          skid_valid_q, skid_valid_d;
  logic [OW-1:0] skid_d_q, skid_d_d;
  logic [OL-1:0] skid_c_q, skid_c_d;
  logic [OL-1:0] skid_e_q, skid_e_d;
  logic          out_fire;

  assign out_fire = out_valid_q & out_ready;

  // Output register with skid: a full skid blocks input, so commit and skid
  // contents never compete for the output register in the same cycle.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_d_d      = out_d_q;
    out_c_d      = out_c_q;
    out_e_d      = out_e_q;
    skid_valid_d = skid_valid_q;
    skid_d_d     = skid_d_q;
    skid_c_d     = skid_c_q;
    skid_e_d     = skid_e_q;
    if (skid_valid_q) begin
      if (out_fire) begin
        out_d_d      = skid_d_q;
        out_c_d      = skid_c_q;
        out_e_d      = skid_e_q;
        skid_valid_d = 1'b0;
      end
    end else if (commit) begin
      if (!out_valid_q || out_ready) begin
        out_d_d     = commit_d;
        out_c_d     = commit_c;
        out_e_d     = commit_e;
        out_valid_d = 1'b1;
      end else begin
        skid_d_d     = commit_d;
        skid_c_d     = commit_c;
        skid_e_d     = commit_e;
        skid_valid_d = 1'b1;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = ~skid_valid_d;
  end

  // Control state and visible outputs, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_d_q      <= '0;
      out_c_q      <= '0;
      out_e_q      <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_d_q      <= out_d_d;
      out_c_q      <= out_c_d;
      out_e_q      <= out_e_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Skid payload, only meaningful while skid_valid_q is set.
  always_ff @(posedge clk) begin
    skid_d_q <= skid_d_d;
    skid_c_q <= skid_c_d;
    skid_e_q <= skid_e_d;
  end

  assign out_valid   = out_valid_q;
  assign out_xgmii_d = out_d_q;
  assign out_xgmii_c = out_c_q;
  assign out_cerr    = out_e_q;

endmodule

// File: tb/tb_xgmii_deinterleave_pipe.sv
// Directed and scoreboarded checks of the XGMII deinterleaver in three
// configurations: RATIO=1 with and without error replacement, and RATIO=2.
module tb_xgmii_deinterleave_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [71:0]  in_dc = '0;
  logic         in_valid = 1'b0, in_align = 1'b0, out_ready = 1'b0;
  logic [63:0]  o1_d, o0_d;
  logic [7:0]   o1_c, o1_e, o0_c, o0_e;
  logic         o1_v, o0_v, rdy1, rdy0;

  logic [71:0]  in2_dc = '0;
  logic         in2_valid = 1'b0, in2_align = 1'b0, out2_ready = 1'b0;
  logic [127:0] o2_d;
  logic [15:0]  o2_c, o2_e;
  logic         o2_v, rdy2;

  xgmii_deinterleave_pipe #(.DATA_WIDTH(64), .RATIO(1), .ERR_REPLACE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_xgmii_dc(in_dc), .in_valid(in_valid),
    .in_ready(rdy1), .in_align(in_align), .out_xgmii_d(o1_d), .out_xgmii_c(o1_c),
    .out_cerr(o1_e), .out_valid(o1_v), .out_ready(out_ready));

  xgmii_deinterleave_pipe #(.DATA_WIDTH(64), .RATIO(1), .ERR_REPLACE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_xgmii_dc(in_dc), .in_valid(in_valid),
    .in_ready(rdy0), .in_align(in_align), .out_xgmii_d(o0_d), .out_xgmii_c(o0_c),
    .out_cerr(o0_e), .out_valid(o0_v), .out_ready(out_ready));

  xgmii_deinterleave_pipe #(.DATA_WIDTH(64), .RATIO(2), .ERR_REPLACE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_xgmii_dc(in2_dc), .in_valid(in2_valid),
    .in_ready(rdy2), .in_align(in2_align), .out_xgmii_d(o2_d), .out_xgmii_c(o2_c),
    .out_cerr(o2_e), .out_valid(o2_v), .out_ready(out2_ready));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] pk(input logic [7:0] c, input logic [63:0] d);
    logic [71:0] r;
    for (int k = 0; k < 8; k++) r[9*k +: 9] = {c[k], d[8*k +: 8]};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] sb_q[$];
  logic [63:0] wdat;
  int          sent, got_n, cyc;

  initial begin
    // Reset values while rst_n is low.
    #1;
    chk("rst_v1",   o1_v, 0);
    chk("rst_d1",   {o1_e, o1_c, o1_d}, 0);
    chk("rst_rdy1", rdy1, 0);
    chk("rst_v2",   o2_v, 0);
    chk("rst_d2",   {o2_d}, 0);
    chk("rst_rdy2", rdy2, 0);
    #21 rst_n = 1'b1;
    #1 chk("rdy_pre_edge", rdy1, 0);
    step();
    chk("rdy_after_edge", rdy1, 1);
    chk("rdy2_after_edge", rdy2, 1);

    // Lane 0 = Start, others data 0x55.
    out_ready = 1'b1;
    in_dc = pk(8'h01, 64'h55555555555555FB);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("start_v", o1_v, 1);
    chk("start_d", o1_d, 64'h55555555555555FB);
    chk("start_c", o1_c, 8'h01);
    chk("start_e", o1_e, 8'h00);

    // Illegal control code 0x12 on lane 3.
    in_dc = pk(8'h08, 64'h0000000012000000);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("err_rep_v", o1_v, 1);
    chk("err_rep_d", o1_d, 64'h00000000FE000000);
    chk("err_rep_c", o1_c, 8'h08);
    chk("err_rep_e", o1_e, 8'h08);
    chk("err_raw_d", o0_d, 64'h0000000012000000);
    chk("err_raw_c", o0_c, 8'h08);
    chk("err_raw_e", o0_e, 8'h08);
    step();
    chk("idle_v", o1_v, 0);

    // Legal codes on every lane must not flag.
    in_dc = pk(8'hFF, 64'h07FBFD9CFE5C0707);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("legal_e", o1_e, 8'h00);
    chk("legal_d", o1_d, 64'h07FBFD9CFE5C0707);

    // RATIO=2 gearbox: A then B.
    out2_ready = 1'b1;
    in2_valid = 1'b1;
    in2_dc = pk(8'h00, 64'h1111111111111111);
    step();
    chk("gb_half_v", o2_v, 0);
    in2_dc = pk(8'hFF, 64'h0707070707070707);
    step();
    in2_valid = 1'b0;
    chk("gb_v", o2_v, 1);
    chk("gb_d", o2_d, 128'h0707070707070707_1111111111111111);
    chk("gb_c", o2_c, 16'hFF00);
    chk("gb_e", o2_e, 16'h0000);
    step();
    chk("gb_one_cycle", o2_v, 0);

    // A, then C with align, then D: output {D,C}, A dropped.
    in2_valid = 1'b1;
    in2_dc = pk(8'h00, 64'h1111111111111111);
    step();
    in2_align = 1'b1;
    in2_dc = pk(8'h00, 64'hCCCCCCCCCCCCCCCC);
    step();
    in2_align = 1'b0;
    chk("align_no_out", o2_v, 0);
    in2_dc = pk(8'h00, 64'hDDDDDDDDDDDDDDDD);
    step();
    in2_valid = 1'b0;
    chk("align_v", o2_v, 1);
    chk("align_d", o2_d, 128'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC);
    step();
    chk("align_done", o2_v, 0);

    // Backpressure: one word held, one in skid, input blocked.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_dc = pk(8'h00, 64'hA1A1A1A1A1A1A1A1);
    step();
    in_dc = pk(8'h00, 64'hA2A2A2A2A2A2A2A2);
    step();
    chk("bp_rdy_low", rdy1, 0);
    in_dc = pk(8'h00, 64'hA3A3A3A3A3A3A3A3);
    step();
    chk("bp_hold_v", o1_v, 1);
    chk("bp_hold_d", o1_d, 64'hA1A1A1A1A1A1A1A1);
    chk("bp_still_blocked", rdy1, 0);
    out_ready = 1'b1;
    step();
    chk("bp_skid_out", o1_d, 64'hA2A2A2A2A2A2A2A2);
    chk("bp_rdy_back", rdy1, 1);
    step();
    in_valid = 1'b0;
    chk("bp_third", o1_d, 64'hA3A3A3A3A3A3A3A3);
    chk("bp_third_v", o1_v, 1);
    step();
    chk("bp_drain", o1_v, 0);

    // Random ready/valid stream against a scoreboard.
    sent = 0; got_n = 0; cyc = 0;
    while ((sent < 10000 || sb_q.size() != 0) && cyc < 60000) begin
      in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      out_ready = (sent >= 10000) || ($urandom_range(0, 3) != 0);
      wdat      = {$urandom, $urandom};
      in_dc     = pk(8'h00, wdat);
      if (o1_v && out_ready) begin
        if (sb_q.size() == 0) chk("rnd_extra", 1, 0);
        else chk("rnd_word", {o1_c, o1_d}, {8'h00, sb_q.pop_front()});
        got_n++;
      end
      if (in_valid && rdy1) begin
        sb_q.push_back(wdat);
        sent++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("rnd_all_sent", sent, 10000);
    chk("rnd_all_recv", got_n, 10000);
    chk("rnd_sb_empty", sb_q.size(), 0);

    // Reset with u1 skid full and u2 half-assembled.
    out_ready = 1'b0;
    out2_ready = 1'b1;
    step();
    in_valid = 1'b1;
    in_dc = pk(8'h00, 64'hB1B1B1B1B1B1B1B1);
    in2_valid = 1'b1;
    in2_dc = pk(8'h00, 64'hEEEEEEEEEEEEEEEE);
    step();
    in2_valid = 1'b0;
    in_dc = pk(8'h00, 64'hB2B2B2B2B2B2B2B2);
    step();
    in_valid = 1'b0;
    chk("mid_skid_full", rdy1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_v1", o1_v, 0);
    chk("mid_rst_d1", {o1_e, o1_c, o1_d}, 0);
    chk("mid_rst_rdy1", rdy1, 0);
    chk("mid_rst_v2", o2_v, 0);
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_rdy1", rdy1, 1);
    out_ready = 1'b1;
    in2_valid = 1'b1;
    in2_dc = pk(8'h00, 64'h0102030405060708);
    step();
    chk("post_rst_half", o2_v, 0);
    chk("post_rst_u1_empty", o1_v, 0);
    in2_dc = pk(8'h00, 64'h1112131415161718);
    step();
    in2_valid = 1'b0;
    chk("post_rst_v2", o2_v, 1);
    chk("post_rst_d2", o2_d, 128'h1112131415161718_0102030405060708);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
